fir_feeder: RTL and testbench

- Initiator for the FIR filter's drive interface (x_n, s_set_coeffs, s_axis_fir_tvalid).
- Holds a host-writable coefficient bank and shifts it into the filter in the order the filter expects.
- Buffers host samples in a small FIFO and streams them to the filter in bursts.
- Sits between the Tiny Tapeout I/O wrapper and the FIR instance; absorbs the filter's reset setup window and its one-cycle state lag.

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_sample_fifo.sv | 44 ++++
 rtl/fir_feeder.sv | 155 +++++++++++++++
 tb/tb_fir_feeder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR feeder and the filter it drives.
// The setup-cycle constant must match the filter's own reset setup window.
package fir_pkg;

  localparam int FIR_TAP_SIZE     = 3;
  localparam int FIR_NBR_OF_TAPS  = 3;
  localparam int FIR_X_N_SIZE     = 8;
  localparam int FIR_FIFO_DEPTH   = 4;
  localparam int FIR_SETUP_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_CONFIG = 3'd2,
    ST_GAP    = 3'd3,
    ST_STREAM = 3'd4
  } fir_state_e;

endpackage

// File: rtl/fir_sample_fifo.sv
// Small synchronous sample FIFO with wrap-bit pointers.
// A push while full is legal only when a pop happens in the same cycle.
module fir_sample_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_pop,
  output logic [DATA_W-1:0]       o_head,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign o_count = r_wptr - r_rptr;
  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/fir_feeder.sv
// Drives the FIR filter's x_n / s_set_coeffs / s_axis_fir_tvalid interface.
// x_n is registered one cycle behind the control strobes to match the filter's state lag.
module fir_feeder
  import fir_pkg::*;
#(
  parameter int TAP_SIZE     = FIR_TAP_SIZE,
  parameter int NBR_OF_TAPS  = FIR_NBR_OF_TAPS,
  parameter int X_N_SIZE     = FIR_X_N_SIZE,
  parameter int FIFO_DEPTH   = FIR_FIFO_DEPTH,
  parameter int SETUP_CYCLES = FIR_SETUP_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             coef_wr,
  input  logic [$clog2(NBR_OF_TAPS)-1:0]   coef_addr,
  input  logic signed [TAP_SIZE-1:0]       coef_data,
  input  logic                             cfg_start,
  input  logic                             in_valid,
  input  logic signed [X_N_SIZE-1:0]       in_data,
  output logic                             in_ready,
  output logic signed [X_N_SIZE-1:0]       x_n,
  output logic                             s_set_coeffs,
  output logic                             s_axis_fir_tvalid,
  output logic                             busy,
  output logic                             cfg_done
);

  localparam int IDX_W = $clog2(NBR_OF_TAPS);
  localparam int CNT_W = $clog2(SETUP_CYCLES + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  fir_state_e                 r_state;
  fir_state_e                 w_state_nxt;
  logic [CNT_W-1:0]           r_wait_cnt;
  logic [IDX_W-1:0]           r_idx;
  logic signed [TAP_SIZE-1:0] r_bank [NBR_OF_TAPS];
  logic                       r_pend;

  logic                       r_set;
  logic                       r_tvalid;
  logic                       r_busy;
  logic                       r_done;
  logic signed [X_N_SIZE-1:0] r_xn;

  logic                       w_set_nxt;
  logic                       w_tvalid_nxt;
  logic                       w_busy_nxt;
  logic                       w_done_nxt;
  logic signed [X_N_SIZE-1:0] w_xn_nxt;

  logic                       w_push;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_empty;
  logic [FCW-1:0]             w_count;
  logic [X_N_SIZE-1:0]        w_head;
  logic                       w_cfg_req;
  logic signed [X_N_SIZE-1:0] w_coef_ext;

  function automatic logic signed [X_N_SIZE-1:0] sext_coef(input logic signed [TAP_SIZE-1:0] c);
    return X_N_SIZE'(c);
  endfunction

  assign w_pop      = (r_state == ST_STREAM);
  assign in_ready   = !w_full || w_pop;
  assign w_push     = in_valid && in_ready;
  assign w_cfg_req  = cfg_start || r_pend;
  assign w_coef_ext = sext_coef(r_bank[r_idx]);

  fir_sample_fifo #(
    .DATA_W (X_N_SIZE),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // STREAM is only ever occupied while the FIFO holds the word being popped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT:   if (r_wait_cnt == CNT_W'(SETUP_CYCLES - 1)) w_state_nxt = ST_IDLE;
      ST_IDLE:   if (w_cfg_req)     w_state_nxt = ST_CONFIG;
                 else if (!w_empty) w_state_nxt = ST_STREAM;
      ST_CONFIG: if (r_idx == '0)   w_state_nxt = ST_GAP;
      ST_GAP:    w_state_nxt = ST_IDLE;
      ST_STREAM: if (w_cfg_req || !((w_count > FCW'(1)) || w_push)) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_WAIT;
    endcase
  end

  always_comb begin
    w_set_nxt    = (w_state_nxt == ST_CONFIG);
    w_tvalid_nxt = (w_state_nxt == ST_STREAM);
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    w_done_nxt   = (w_state_nxt == ST_GAP);
    w_xn_nxt     = '0;
    if (r_state == ST_CONFIG)      w_xn_nxt = w_coef_ext;
    else if (r_state == ST_STREAM) w_xn_nxt = w_head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set      <= 1'b0;
      r_tvalid   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_xn       <= '0;
      r_wait_cnt <= '0;
      r_idx      <= '0;
      r_pend     <= 1'b0;
      for (int i = 0; i < NBR_OF_TAPS; i++) r_bank[i] <= '0;
    end else begin
      r_set    <= w_set_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_xn     <= w_xn_nxt;

      r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 1'b1 : '0;

      // Highest index goes out first so bank[0] ends up in the filter's taps[0].
      if (r_state != ST_CONFIG && w_state_nxt == ST_CONFIG) r_idx <= IDX_W'(NBR_OF_TAPS - 1);
      else if (r_state == ST_CONFIG)                        r_idx <= r_idx - 1'b1;

      if (r_state == ST_IDLE) r_pend <= 1'b0;
      else if (cfg_start)     r_pend <= 1'b1;

      if (coef_wr && r_state != ST_CONFIG && int'(coef_addr) < NBR_OF_TAPS)
        r_bank[coef_addr] <= coef_data;
    end
  end

  assign s_set_coeffs      = r_set;
  assign s_axis_fir_tvalid = r_tvalid;
  assign busy              = r_busy;
  assign cfg_done          = r_done;
  assign x_n               = r_xn;

endmodule

// File: tb/tb_fir_feeder.sv
// Directed bench for fir_feeder: setup window, coefficient load order, streaming,
// FIFO backpressure, configuration preempting a stream, and reset mid-load.
module tb_fir_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coef_wr = 1'b0;
  logic [1:0] coef_addr = '0;
  logic [2:0] coef_data = '0;
  logic       cfg_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [7:0] x_n;
  logic       s_set_coeffs;
  logic       s_axis_fir_tvalid;
  logic       busy;
  logic       cfg_done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fir_feeder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .coef_wr           (coef_wr),
    .coef_addr         (coef_addr),
    .coef_data         (coef_data),
    .cfg_start         (cfg_start),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .x_n               (x_n),
    .s_set_coeffs      (s_set_coeffs),
    .s_axis_fir_tvalid (s_axis_fir_tvalid),
    .busy              (busy),
    .cfg_done          (cfg_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed as {s_set_coeffs, tvalid, busy, cfg_done, x_n}.
  function automatic logic [11:0] ex(input logic s, input logic t, input logic b,
                                     input logic d, input logic [7:0] x);
    return {s, t, b, d, x};
  endfunction

  task automatic chk(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {s_set_coeffs, s_axis_fir_tvalid, busy, cfg_done, x_n};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed={set,tv,busy,done,x_n}=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    total++;
    assert (in_ready === exp) passed++;
    else $error("FAIL %s observed in_ready=%b expected=%b", tag, in_ready, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Setup window with cfg_start held from the first cycle after release
    cfg_start = 1'b1;
    step(); step();
    chk("reset_hold", ex(0, 0, 0, 0, 8'h00));
    rst_n = 1'b1;
    chk("wait_c0", ex(0, 0, 0, 0, 8'h00));
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("wait_c%0d", c), ex(0, 0, 1, 0, 8'h00));
    end
    step(); cfg_start = 1'b0;
    chk("wait_idle_c4", ex(0, 0, 0, 0, 8'h00));
    step(); chk("cfg0_c5", ex(1, 0, 1, 0, 8'h00));
    step(); chk("cfg0_c6", ex(1, 0, 1, 0, 8'h00));
    step(); chk("cfg0_c7", ex(1, 0, 1, 0, 8'h00));
    step(); chk("cfg0_gap", ex(0, 0, 1, 1, 8'h00));
    step(); chk("cfg0_idle", ex(0, 0, 0, 0, 8'h00));

    // Bank = {1, 0, -1}, then load it
    coef_wr = 1'b1; coef_addr = 2'd0; coef_data = 3'b001;
    step(); coef_addr = 2'd1; coef_data = 3'b000;
    step(); coef_addr = 2'd2; coef_data = 3'b111;
    step(); coef_wr = 1'b0; cfg_start = 1'b1;
    chk("load_idle", ex(0, 0, 0, 0, 8'h00));
    step(); cfg_start = 1'b0;
    chk("load_s0", ex(1, 0, 1, 0, 8'h00));
    step(); chk("load_s1_bank2", ex(1, 0, 1, 0, 8'hFF));
    step(); chk("load_s2_bank1", ex(1, 0, 1, 0, 8'h00));
    step(); chk("load_gap_bank0", ex(0, 0, 1, 1, 8'h01));
    step(); chk("load_idle_after", ex(0, 0, 0, 0, 8'h00));

    // Back-to-back samples 5, 3, -2
    in_valid = 1'b1; in_data = 8'd5;
    chk_rdy("stream_rdy_empty", 1'b1);
    step(); in_data = 8'd3;
    chk("stream_idle", ex(0, 0, 0, 0, 8'h00));
    step(); in_data = 8'hFE;
    chk("stream_v0", ex(0, 1, 1, 0, 8'h00));
    step(); in_valid = 1'b0;
    chk("stream_x5", ex(0, 1, 1, 0, 8'h05));
    step(); chk("stream_x3", ex(0, 1, 1, 0, 8'h03));
    step(); chk("stream_xm2", ex(0, 0, 0, 0, 8'hFE));
    step(); chk("stream_end", ex(0, 0, 0, 0, 8'h00));

    // Fill the FIFO while a load keeps it from draining
    cfg_start = 1'b1;
    step(); cfg_start = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
    chk("fill_cfg0", ex(1, 0, 1, 0, 8'h00));
    chk_rdy("fill_rdy0", 1'b1);
    step(); in_data = 8'h0B;
    chk("fill_cfg1", ex(1, 0, 1, 0, 8'hFF));
    step(); in_data = 8'h0C;
    chk("fill_cfg2", ex(1, 0, 1, 0, 8'h00));
    step(); in_data = 8'h0D;
    chk("fill_gap", ex(0, 0, 1, 1, 8'h01));
    chk_rdy("fill_rdy3", 1'b1);
    step(); in_data = 8'h0E;
    chk("fill_idle", ex(0, 0, 0, 0, 8'h00));
    chk_rdy("fill_full", 1'b0);
    step();
    chk("fill_pop0", ex(0, 1, 1, 0, 8'h00));
    chk_rdy("fill_pop_frees", 1'b1);
    step(); in_valid = 1'b0;
    chk("fill_x0A", ex(0, 1, 1, 0, 8'h0A));
    step(); chk("fill_x0B", ex(0, 1, 1, 0, 8'h0B));
    step(); chk("fill_x0C", ex(0, 1, 1, 0, 8'h0C));
    step(); chk("fill_x0D", ex(0, 1, 1, 0, 8'h0D));
    step(); chk("fill_x0E", ex(0, 0, 0, 0, 8'h0E));
    step(); chk("fill_end", ex(0, 0, 0, 0, 8'h00));

    // cfg_start in the second cycle of a four-sample stream
    in_valid = 1'b1; in_data = 8'h21;
    step(); in_data = 8'h22;
    chk("pre_idle", ex(0, 0, 0, 0, 8'h00));
    step(); in_data = 8'h23;
    chk("pre_v0", ex(0, 1, 1, 0, 8'h00));
    step(); in_data = 8'h24; cfg_start = 1'b1;
    chk("pre_v1", ex(0, 1, 1, 0, 8'h21));
    step(); in_valid = 1'b0; cfg_start = 1'b0;
    chk("pre_idle_x22", ex(0, 0, 0, 0, 8'h22));
    step(); chk("pre_cfg0", ex(1, 0, 1, 0, 8'h00));
    step(); chk("pre_cfg1", ex(1, 0, 1, 0, 8'hFF));
    step(); chk("pre_cfg2", ex(1, 0, 1, 0, 8'h00));
    step(); chk("pre_gap", ex(0, 0, 1, 1, 8'h01));
    step(); chk("pre_idle2", ex(0, 0, 0, 0, 8'h00));
    step(); chk("pre_resume_v", ex(0, 1, 1, 0, 8'h00));
    step(); chk("pre_x23", ex(0, 1, 1, 0, 8'h23));
    step(); chk("pre_x24", ex(0, 0, 0, 0, 8'h24));
    step(); chk("pre_end", ex(0, 0, 0, 0, 8'h00));

    // Reset in the second CONFIG cycle with one sample queued
    cfg_start = 1'b1;
    step(); cfg_start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    chk("rst_cfg0", ex(1, 0, 1, 0, 8'h00));
    step(); in_valid = 1'b0;
    chk("rst_cfg1", ex(1, 0, 1, 0, 8'hFF));
    #2 rst_n = 1'b0;
    #1 chk("rst_async", ex(0, 0, 0, 0, 8'h00));
    step();
    chk("rst_held", ex(0, 0, 0, 0, 8'h00));
    rst_n = 1'b1;
    chk("rst_wait_c0", ex(0, 0, 0, 0, 8'h00));
    chk_rdy("rst_fifo_empty", 1'b1);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("rst_wait_c%0d", c), ex(0, 0, 1, 0, 8'h00));
    end
    step(); chk("rst_idle", ex(0, 0, 0, 0, 8'h00));
    step(); chk("rst_no_stream", ex(0, 0, 0, 0, 8'h00));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
